instruction_decode: RTL and testbench

- ID stage of the 5-stage LA32R pipeline; directly downstream of the IF stage.
- Latches {inst, pc} from IF under valid/allowin handshake and decodes the instruction.
- Reads two register-file ports, resolves RAW hazards, evaluates branches and redirects IF via branch_bus.
- Issues a packed operation bundle to EXE.

---
 rtl/instruction_decode.sv | 212 +++++++++++++++++++++
 tb/tb_instruction_decode.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_decode.sv
// LA32R ID stage: latches the IF handoff, decodes, resolves RAW hazards and branches, issues to EXE.
// Build option DEC_BYPASS_EN: operand forwarding from exe/mem/wb with load-use stall only.
module instruction_decode #(
  parameter logic [31:0] RESET_PC = 32'h1bfffffc
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         fetch_to_dec_valid,
  input  logic [63:0]  fetch_to_decode_bus,
  output logic         dec_allowin,
  output logic [32:0]  branch_bus,
  input  logic         exe_allowin,
  output logic         dec_to_exe_valid,
  output logic [147:0] dec_to_exe_bus,
  output logic [4:0]   rf_raddr1,
  output logic [4:0]   rf_raddr2,
  input  logic [31:0]  rf_rdata1,
  input  logic [31:0]  rf_rdata2,
  input  logic [38:0]  exe_fwd_bus,
  input  logic [37:0]  mem_fwd_bus,
  input  logic [37:0]  wb_fwd_bus
);

  typedef struct packed {
    logic [11:0] alu_op;
    logic        mem_we;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] rkd_value;
    logic [31:0] pc;
  } exe_bundle_t;

  logic        dec_valid_q, dec_valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_q, pc_d;
  logic        dec_ready_go;
  logic        br_taken;
  logic [31:0] br_target;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dec_valid_q <= 1'b0;
      inst_q      <= '0;
      pc_q        <= RESET_PC;
    end else begin
      dec_valid_q <= dec_valid_d;
      inst_q      <= inst_d;
      pc_q        <= pc_d;
    end
  end

  assign dec_allowin      = ~dec_valid_q | (dec_ready_go & exe_allowin);
  assign dec_to_exe_valid = dec_valid_q & dec_ready_go;

  // A taken branch kills whatever IF hands over in the same cycle.
  always_comb begin
    dec_valid_d = dec_valid_q;
    inst_d      = inst_q;
    pc_d        = pc_q;
    if (dec_allowin) dec_valid_d = fetch_to_dec_valid & ~br_taken;
    if (fetch_to_dec_valid & dec_allowin) {inst_d, pc_d} = fetch_to_decode_bus;
  end

  // ---------------- decode ----------------
  logic [4:0] rd, rj, rk;
  assign rd = inst_q[4:0];
  assign rj = inst_q[9:5];
  assign rk = inst_q[14:10];

  logic [16:0] op17;
  logic [9:0]  op10;
  logic [5:0]  op6;
  assign op17 = inst_q[31:15];
  assign op10 = inst_q[31:22];
  assign op6  = inst_q[31:26];

  logic i_add, i_sub, i_slt, i_sltu, i_nor, i_and, i_or, i_xor;
  logic i_slli, i_srli, i_srai, i_addi, i_lu12i, i_ld, i_st;
  logic i_jirl, i_b, i_bl, i_beq, i_bne;

  assign i_add   = op17 == 17'h00020;
  assign i_sub   = op17 == 17'h00022;
  assign i_slt   = op17 == 17'h00024;
  assign i_sltu  = op17 == 17'h00025;
  assign i_nor   = op17 == 17'h00028;
  assign i_and   = op17 == 17'h00029;
  assign i_or    = op17 == 17'h0002a;
  assign i_xor   = op17 == 17'h0002b;
  assign i_slli  = op17 == 17'h00081;
  assign i_srli  = op17 == 17'h00089;
  assign i_srai  = op17 == 17'h00091;
  assign i_addi  = op10 == 10'h00a;
  assign i_ld    = op10 == 10'h0a2;
  assign i_st    = op10 == 10'h0a6;
  assign i_lu12i = inst_q[31:25] == 7'h0a;
  assign i_jirl  = op6 == 6'h13;
  assign i_b     = op6 == 6'h14;
  assign i_bl    = op6 == 6'h15;
  assign i_beq   = op6 == 6'h16;
  assign i_bne   = op6 == 6'h17;

  logic is_3r, is_shift, is_si12, link, src2_rd, rj_used, r2_used;
  assign is_3r    = i_add | i_sub | i_slt | i_sltu | i_nor | i_and | i_or | i_xor;
  assign is_shift = i_slli | i_srli | i_srai;
  assign is_si12  = i_addi | i_ld | i_st;
  assign link     = i_jirl | i_bl;
  assign src2_rd  = i_st | i_beq | i_bne;
  assign rj_used  = is_3r | is_shift | is_si12 | i_jirl | i_beq | i_bne;
  assign r2_used  = is_3r | src2_rd;

  assign rf_raddr1 = rj;
  assign rf_raddr2 = src2_rd ? rd : rk;

  logic [31:0] imm_si12, imm_ui5, imm_si20, offs16, offs26;
  assign imm_si12 = {{20{inst_q[21]}}, inst_q[21:10]};
  assign imm_ui5  = {27'b0, inst_q[14:10]};
  assign imm_si20 = {inst_q[24:5], 12'b0};
  assign offs16   = {{14{inst_q[25]}}, inst_q[25:10], 2'b0};
  assign offs26   = {{4{inst_q[9]}}, inst_q[9:0], inst_q[25:10], 2'b0};

  // ---------------- hazards / operands ----------------
  function automatic logic hit(input logic v, input logic [4:0] d, input logic [4:0] r);
    return v && (d != 5'd0) && (d == r);
  endfunction

  logic rj_exe, rj_mem, rj_wb, r2_exe, r2_mem, r2_wb;
  assign rj_exe = hit(exe_fwd_bus[38], exe_fwd_bus[36:32], rf_raddr1);
  assign rj_mem = hit(mem_fwd_bus[37], mem_fwd_bus[36:32], rf_raddr1);
  assign rj_wb  = hit(wb_fwd_bus[37],  wb_fwd_bus[36:32],  rf_raddr1);
  assign r2_exe = hit(exe_fwd_bus[38], exe_fwd_bus[36:32], rf_raddr2);
  assign r2_mem = hit(mem_fwd_bus[37], mem_fwd_bus[36:32], rf_raddr2);
  assign r2_wb  = hit(wb_fwd_bus[37],  wb_fwd_bus[36:32],  rf_raddr2);

  logic [31:0] rj_value, rkd_value;

`ifdef DEC_BYPASS_EN
  // Youngest producer wins; a load still in exe has no data yet.
  always_comb begin
    rj_value = rf_rdata1;
    if (rj_exe)      rj_value = exe_fwd_bus[31:0];
    else if (rj_mem) rj_value = mem_fwd_bus[31:0];
    else if (rj_wb)  rj_value = wb_fwd_bus[31:0];
    if (rf_raddr1 == 5'd0) rj_value = '0;
  end

  always_comb begin
    rkd_value = rf_rdata2;
    if (r2_exe)      rkd_value = exe_fwd_bus[31:0];
    else if (r2_mem) rkd_value = mem_fwd_bus[31:0];
    else if (r2_wb)  rkd_value = wb_fwd_bus[31:0];
    if (rf_raddr2 == 5'd0) rkd_value = '0;
  end

  assign dec_ready_go = ~(exe_fwd_bus[37] & ((rj_used & rj_exe) | (r2_used & r2_exe)));
`else
  assign rj_value  = (rf_raddr1 == 5'd0) ? 32'h0 : rf_rdata1;
  assign rkd_value = (rf_raddr2 == 5'd0) ? 32'h0 : rf_rdata2;

  // Wait until no in-flight stage still owns a source register.
  assign dec_ready_go = ~((rj_used & (rj_exe | rj_mem | rj_wb)) |
                          (r2_used & (r2_exe | r2_mem | r2_wb)));

  logic unused_fwd;
  assign unused_fwd = ^{exe_fwd_bus[37], exe_fwd_bus[31:0], mem_fwd_bus[31:0], wb_fwd_bus[31:0]};
`endif

  // ---------------- branch ----------------
  logic rs_equal, br_cond;
  assign rs_equal  = rj_value == rkd_value;
  assign br_cond   = i_b | i_bl | i_jirl | (i_beq & rs_equal) | (i_bne & ~rs_equal);
  assign br_taken  = dec_valid_q & dec_ready_go & exe_allowin & br_cond;
  assign br_target = i_jirl ? (rj_value + offs16)
                            : (pc_q + ((i_b | i_bl) ? offs26 : offs16));
  assign branch_bus = {br_taken, br_taken ? br_target : 32'h0};

  // ---------------- issue bundle ----------------
  exe_bundle_t bnd;

  always_comb begin
    bnd = '0;
    bnd.alu_op[0]  = i_add | i_addi | i_ld | i_st | link;
    bnd.alu_op[1]  = i_sub;
    bnd.alu_op[2]  = i_slt;
    bnd.alu_op[3]  = i_sltu;
    bnd.alu_op[4]  = i_and;
    bnd.alu_op[5]  = i_nor;
    bnd.alu_op[6]  = i_or;
    bnd.alu_op[7]  = i_xor;
    bnd.alu_op[8]  = i_slli;
    bnd.alu_op[9]  = i_srli;
    bnd.alu_op[10] = i_srai;
    bnd.alu_op[11] = i_lu12i;
    bnd.mem_we       = i_st;
    bnd.res_from_mem = i_ld;
    bnd.gr_we        = is_3r | is_shift | i_addi | i_ld | i_lu12i | link;
    bnd.dest         = i_bl ? 5'd1 : rd;
    bnd.src1         = link ? pc_q : rj_value;
    if (link)          bnd.src2 = 32'd4;
    else if (is_si12)  bnd.src2 = imm_si12;
    else if (is_shift) bnd.src2 = imm_ui5;
    else if (i_lu12i)  bnd.src2 = imm_si20;
    else               bnd.src2 = rkd_value;
    bnd.rkd_value    = rkd_value;
    bnd.pc           = pc_q;
  end

  assign dec_to_exe_bus = bnd;

endmodule

// File: tb/tb_instruction_decode.sv
// Scoreboarded bench for instruction_decode: directed vectors, expected bundles queued at issue.
module tb_instruction_decode;
  logic         clk = 1'b0;
  logic         reset;
  logic         fetch_to_dec_valid;
  logic [63:0]  fetch_to_decode_bus;
  logic         dec_allowin;
  logic [32:0]  branch_bus;
  logic         exe_allowin;
  logic         dec_to_exe_valid;
  logic [147:0] dec_to_exe_bus;
  logic [4:0]   rf_raddr1, rf_raddr2;
  logic [31:0]  rf_rdata1, rf_rdata2;
  logic [38:0]  exe_fwd_bus;
  logic [37:0]  mem_fwd_bus, wb_fwd_bus;

  logic [31:0]  rf [32];
  logic [147:0] sbq [$];
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign rf_rdata1 = rf[rf_raddr1];
  assign rf_rdata2 = rf[rf_raddr2];

  instruction_decode dut (
    .clk(clk), .reset(reset),
    .fetch_to_dec_valid(fetch_to_dec_valid), .fetch_to_decode_bus(fetch_to_decode_bus),
    .dec_allowin(dec_allowin), .branch_bus(branch_bus), .exe_allowin(exe_allowin),
    .dec_to_exe_valid(dec_to_exe_valid), .dec_to_exe_bus(dec_to_exe_bus),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .exe_fwd_bus(exe_fwd_bus), .mem_fwd_bus(mem_fwd_bus), .wb_fwd_bus(wb_fwd_bus)
  );

  function automatic logic [147:0] bund(input logic [11:0] op, input logic mw, input logic rfm,
                                        input logic gw, input logic [4:0] d, input logic [31:0] s1,
                                        input logic [31:0] s2, input logic [31:0] rkd,
                                        input logic [31:0] pc);
    return {op, mw, rfm, gw, d, s1, s2, rkd, pc};
  endfunction

  task automatic chk(input string nm, input logic [147:0] act, input logic [147:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted bundle is matched against the head of the scoreboard.
  initial begin
    logic [147:0] e;
    forever begin
      @(negedge clk);
      if (!reset && dec_to_exe_valid && exe_allowin) begin
        n_chk++;
        if (sbq.size() == 0) begin
          n_fail++;
          $display("FAIL issue: unexpected bundle %h", dec_to_exe_bus);
        end else begin
          e = sbq.pop_front();
          if (dec_to_exe_bus !== e) begin
            n_fail++;
            $display("FAIL issue pc=%h: got %h expected %h", e[31:0], dec_to_exe_bus, e);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  // One instruction with a bubble after it; the branch outcome is checked in its issue cycle.
  task automatic issue1(input string nm, input logic [31:0] inst, input logic [31:0] pc,
                        input logic [147:0] eb, input logic [32:0] ebr);
    fetch_to_dec_valid  = 1'b1;
    fetch_to_decode_bus = {inst, pc};
    sbq.push_back(eb);
    step();
    fetch_to_dec_valid = 1'b0;
    @(negedge clk);
    chk({nm, " branch"}, branch_bus, ebr);
    step();
  endtask

  initial begin
    logic [147:0] e_add;
    reset = 1'b1;
    fetch_to_dec_valid = 1'b0;
    fetch_to_decode_bus = '0;
    exe_allowin = 1'b1;
    exe_fwd_bus = '0;
    mem_fwd_bus = '0;
    wb_fwd_bus = '0;
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    rf[1] = 32'd7;
    rf[2] = 32'd7;
    rf[3] = 32'h1c001000;
    rf[9] = 32'h80000000;

    #3;
    chk("reset valid", dec_to_exe_valid, 0);
    chk("reset allowin", dec_allowin, 1);
    chk("reset branch", branch_bus, 0);
    chk("reset pc", dec_to_exe_bus[31:0], 32'h1bfffffc);
    step();
    reset = 1'b0;

    // addi.w r4,r0,5 then beq r1,r2,+8 back to back
    fetch_to_dec_valid  = 1'b1;
    fetch_to_decode_bus = {10'h00a, 12'd5, 5'd0, 5'd4, 32'h1c000000};
    sbq.push_back(bund(12'h001, 0, 0, 1, 5'd4, 32'h0, 32'd5, 32'h0, 32'h1c000000));
    step();
    fetch_to_decode_bus = {6'h16, 16'd2, 5'd1, 5'd2, 32'h1c000010};
    sbq.push_back(bund(12'h000, 0, 0, 0, 5'd2, 32'd7, 32'd7, 32'd7, 32'h1c000010));
    @(negedge clk);
    chk("addi valid", dec_to_exe_valid, 1);
    step();
    fetch_to_decode_bus = {10'h00a, 12'd1, 5'd0, 5'd9, 32'h1c000014};
    @(negedge clk);
    chk("beq branch", branch_bus, {1'b1, 32'h1c000018});
    step();
    fetch_to_dec_valid = 1'b0;
    @(negedge clk);
    chk("beq shadow killed", dec_to_exe_valid, 0);
    chk("beq shadow allowin", dec_allowin, 1);
    step();

    // EXE back-pressure for three cycles
    e_add = bund(12'h001, 0, 0, 1, 5'd5, 32'd7, 32'd7, 32'd7, 32'h1c000018);
    fetch_to_dec_valid  = 1'b1;
    fetch_to_decode_bus = {17'h00020, 5'd2, 5'd1, 5'd5, 32'h1c000018};
    sbq.push_back(e_add);
    step();
    exe_allowin = 1'b0;
    fetch_to_decode_bus = {32'hffffffff, 32'h1c00001c};
    sbq.push_back(bund(12'h000, 0, 0, 0, 5'd31, 32'h0, 32'h0, 32'h0, 32'h1c00001c));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold allowin", dec_allowin, 0);
      chk("hold bundle", dec_to_exe_bus, e_add);
      step();
    end
    exe_allowin = 1'b1;
    step();
    fetch_to_dec_valid = 1'b0;
    step();

    issue1("bl", {6'h15, 16'h0040, 10'h000}, 32'h1c000100,
           bund(12'h001, 0, 0, 1, 5'd1, 32'h1c000100, 32'd4, 32'h0, 32'h1c000100),
           {1'b1, 32'h1c000200});
    issue1("jirl", {6'h13, 16'd4, 5'd3, 5'd1}, 32'h1c000200,
           bund(12'h001, 0, 0, 1, 5'd1, 32'h1c000200, 32'd4, 32'h0, 32'h1c000200),
           {1'b1, 32'h1c001010});
    issue1("st.w", {10'h0a6, 12'hffc, 5'd1, 5'd2}, 32'h1c000300,
           bund(12'h001, 1, 0, 0, 5'd2, 32'd7, 32'hfffffffc, 32'd7, 32'h1c000300), 33'h0);
    issue1("lu12i", {7'h0a, 20'h12345, 5'd7}, 32'h1c000304,
           bund(12'h800, 0, 0, 1, 5'd7, 32'h0, 32'h12345000, 32'h0, 32'h1c000304), 33'h0);
    issue1("bne nt", {6'h17, 16'hffff, 5'd1, 5'd2}, 32'h1c000308,
           bund(12'h000, 0, 0, 0, 5'd2, 32'd7, 32'd7, 32'd7, 32'h1c000308), 33'h0);
    issue1("srai", {17'h00091, 5'd4, 5'd9, 5'd8}, 32'h1c00030c,
           bund(12'h400, 0, 0, 1, 5'd8, 32'h80000000, 32'd4, 32'h0, 32'h1c00030c), 33'h0);
    issue1("ld.w", {10'h0a2, 12'd8, 5'd1, 5'd10}, 32'h1c000310,
           bund(12'h001, 0, 1, 1, 5'd10, 32'd7, 32'd8, 32'h0, 32'h1c000310), 33'h0);
    issue1("sub.w", {17'h00022, 5'd3, 5'd1, 5'd11}, 32'h1c000314,
           bund(12'h002, 0, 0, 1, 5'd11, 32'd7, 32'h1c001000, 32'h1c001000, 32'h1c000314), 33'h0);
    issue1("bne t", {6'h17, 16'd2, 5'd1, 5'd3}, 32'h1c000318,
           bund(12'h000, 0, 0, 0, 5'd3, 32'd7, 32'h1c001000, 32'h1c001000, 32'h1c000318),
           {1'b1, 32'h1c000320});

    // RAW on r4: producer walks exe -> mem -> wb -> regfile
    rf[4] = 32'h99;
    fetch_to_dec_valid  = 1'b1;
    fetch_to_decode_bus = {17'h00020, 5'd4, 5'd4, 5'd5, 32'h1c000020};
    sbq.push_back(bund(12'h001, 0, 0, 1, 5'd5, 32'h10, 32'h10, 32'h10, 32'h1c000020));
    step();
    fetch_to_dec_valid = 1'b0;
    exe_fwd_bus = {1'b1, 1'b0, 5'd4, 32'h10};
    @(negedge clk);
`ifdef DEC_BYPASS_EN
    chk("raw bypass valid", dec_to_exe_valid, 1);
`else
    chk("raw stall exe", dec_to_exe_valid, 0);
    chk("raw stall allowin", dec_allowin, 0);
`endif
    step();
    exe_fwd_bus = '0;
    mem_fwd_bus = {1'b1, 5'd4, 32'h10};
`ifndef DEC_BYPASS_EN
    @(negedge clk);
    chk("raw stall mem", dec_to_exe_valid, 0);
`endif
    step();
    mem_fwd_bus = '0;
    wb_fwd_bus  = {1'b1, 5'd4, 32'h10};
`ifndef DEC_BYPASS_EN
    @(negedge clk);
    chk("raw stall wb", dec_to_exe_valid, 0);
`endif
    step();
    wb_fwd_bus = '0;
    rf[4] = 32'h10;
`ifndef DEC_BYPASS_EN
    @(negedge clk);
    chk("raw release", dec_to_exe_valid, 1);
`endif
    step();

`ifdef DEC_BYPASS_EN
    // load-use: one bubble, then the mem-stage value
    fetch_to_dec_valid  = 1'b1;
    fetch_to_decode_bus = {17'h00020, 5'd0, 5'd4, 5'd6, 32'h1c000024};
    sbq.push_back(bund(12'h001, 0, 0, 1, 5'd6, 32'h77, 32'h0, 32'h0, 32'h1c000024));
    step();
    fetch_to_dec_valid = 1'b0;
    exe_fwd_bus = {1'b1, 1'b1, 5'd4, 32'hdead};
    @(negedge clk);
    chk("load-use stall", dec_to_exe_valid, 0);
    chk("load-use allowin", dec_allowin, 0);
    step();
    exe_fwd_bus = '0;
    mem_fwd_bus = {1'b1, 5'd4, 32'h77};
    @(negedge clk);
    chk("load-use release", dec_to_exe_valid, 1);
    step();
    mem_fwd_bus = '0;
    step();
`endif

    // Reset while a bundle is held by EXE back-pressure
    exe_allowin = 1'b0;
    fetch_to_dec_valid  = 1'b1;
    fetch_to_decode_bus = {32'hffffffff, 32'h1c000400};
    step();
    fetch_to_dec_valid = 1'b0;
    chk("pre-reset valid", dec_to_exe_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid reset valid", dec_to_exe_valid, 0);
    chk("mid reset allowin", dec_allowin, 1);
    chk("mid reset branch", branch_bus, 0);
    chk("mid reset pc", dec_to_exe_bus[31:0], 32'h1bfffffc);
    step();
    reset = 1'b0;
    exe_allowin = 1'b1;
    step();
    step();
    chk("scoreboard drained", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
